energy_peak_tracker: RTL
========================

# energy_peak_tracker

Downstream consumer of the 12-channel square-add energy stage. Each valid input is the 64-bit beam energy for one steering direction. Directions arrive in fixed round-robin order 0..NUM_DIR-1. The block integrates each direction's energy over a window of 2^WIN_LOG2 frames, then reports the direction with the largest integrated energy. The upstream stage has no back-pressure, so accumulators are double-banked: one bank accumulates while the other is scanned, and every valid input is accepted.

## Interface
- NUM_DIR, 8: steering directions per frame (≥2); DW = $clog2(NUM_DIR)
- WIN_LOG2, 2: log2 of frames per window (≥1); AW = 64+WIN_LOG2 accumulator width
- i_50M_clk  input  1  system clock, rising-edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_valid  input  1  energy sample valid (driven by square-add o_ready)
- i_energy  input  64  signed energy sample (square-add o_square_add_data)
- i_clear  input  1  synchronous restart; clears counters, active bank and scan
- o_valid  output  1  one-cycle pulse, result valid
- o_dir  output  DW  winning direction index
- o_peak  output  AW  unsigned integrated energy of winner
- o_frame_idx  output  WIN_LOG2  current frame index within window being accumulated

## Operation
- Counters:
  - dir_cnt (0..NUM_DIR-1) and frame_cnt (0..2^WIN_LOG2-1) advance only on accepted samples.
  - dir_cnt wraps to 0 and increments frame_cnt.
  - frame_cnt wraps to 0 at window end.
- Input clamp: i_energy < 0 is treated as 0. Stored values are unsigned, zero-extended to AW.
- Accumulate:
  - On a valid sample, acc[bank_w][dir_cnt] += clamped energy.
  - When frame_cnt==0, the entry is loaded with the sample instead of added. This clears stale data from the previous window without a clear pass.
  - No saturation is needed: AW holds 2^WIN_LOG2 maximal samples.
- Window end: the sample with dir_cnt==NUM_DIR-1 and frame_cnt==2^WIN_LOG2-1 is written, then bank_w toggles at that same edge. The scan FSM is launched on the finished bank.
- Scan FSM states:
  - IDLE → SCAN on window end.
  - SCAN reads index k=0..NUM_DIR-1, one per cycle, tracking best value and best index.
  - Replacement is strict greater-than only, so ties resolve to the lowest index. Best value is initialised from k=0.
  - SCAN → DONE after k=NUM_DIR-1.
  - DONE: register o_dir/o_peak, pulse o_valid, → IDLE.
- Simultaneous events: a valid sample during SCAN/DONE writes only bank_w and never disturbs the bank under scan. The minimum window of NUM_DIR·2^WIN_LOG2 cycles exceeds the scan length NUM_DIR+1, so no overrun is possible.
- i_clear priority:
  - Overrides i_valid in the same cycle; that sample is dropped.
  - Zeros dir_cnt and frame_cnt and aborts SCAN/DONE without an o_valid.
  - Leaves bank_w unchanged.
  - Holds o_dir/o_peak at their last values.
- Reset mid-operation: all state returns to reset values immediately; any partial window is discarded.

## Timing
- Reset values:
  - o_valid=0, o_dir=0, o_peak=0, o_frame_idx=0.
  - dir_cnt=0, frame_cnt=0, bank_w=0, FSM=IDLE.
  - Accumulator contents need no reset, because frame 0 overwrites them.
- Latency: if the final window sample is sampled at rising edge T, o_valid is high in the cycle following edge T+NUM_DIR+1.
  - Default NUM_DIR=8: o_valid rises 9 edges after the last sample.
- o_valid is exactly one cycle wide.
- o_dir/o_peak change only on the edge that raises o_valid, and hold until the next result.
- Gaps in i_valid (any length) stall the counters only; alignment is preserved.
- o_frame_idx equals frame_cnt, registered.

## Test plan
- Ramp: 4 frames, dir d energy = 100·(d+1) every frame → one o_valid, o_dir=7, o_peak=3200, 9 edges after sample 32.
- Tie and negative clamp: all directions 50, except dir 3 = -1000 in frame 0 and 50 elsewhere → dir 3 sums to 150, others 200 → o_dir=0, o_peak=200.
- Max magnitude: dir 5 = 64'h7FFF_FFFF_FFFF_FFFF in all 4 frames, others 1 → o_dir=5, o_peak=66'h1_FFFF_FFFF_FFFF_FFFC.
- Back-to-back with gaps: window A peak at dir 2 (value 10/frame, others 0) and window B peak at dir 6 (7/frame). B starts the cycle after A's last sample, with random 0–3 cycle i_valid gaps → two pulses: (2,40) then (6,28). Window B accumulation is unaffected during A's scan.
- Reset mid-window: 10 samples of 999, then i_rst_n low for one cycle, then the ramp scenario → exactly one o_valid with (7,3200). Outputs read 0 right after reset.
- i_clear during SCAN: assert i_clear 3 cycles after a window end → no o_valid, o_dir/o_peak keep previous values. A following full ramp window yields (7,3200).

Source files
------------

// File: rtl/energy_peak_tracker.sv
// energy_peak_tracker: windowed per-direction energy integration with double-banked argmax scan.
module energy_peak_tracker #(
  parameter  int NUM_DIR  = 8,
  parameter  int WIN_LOG2 = 2,
  localparam int DW = $clog2(NUM_DIR),
  localparam int AW = 64 + WIN_LOG2
) (
  input  logic                i_50M_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic [63:0]         i_energy,
  input  logic                i_clear,
  output logic                o_valid,
  output logic [DW-1:0]       o_dir,
  output logic [AW-1:0]       o_peak,
  output logic [WIN_LOG2-1:0] o_frame_idx
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [DW-1:0] LAST_DIR = DW'(NUM_DIR - 1);
  state_t state, state_d;
  logic [DW-1:0] dir_cnt, k, best_idx;
  logic [WIN_LOG2-1:0] frame_cnt;
  logic bank_w, accept, last_dir, win_end, last_k;
  logic [AW-1:0] acc [2][NUM_DIR];
  logic [AW-1:0] ext, rd, best_val;
  assign accept      = i_valid & ~i_clear;
  assign last_dir    = dir_cnt == LAST_DIR;
  assign win_end     = accept & last_dir & (&frame_cnt);
  assign last_k      = k == LAST_DIR;
  assign ext         = i_energy[63] ? '0 : {{WIN_LOG2{1'b0}}, i_energy};
  assign rd          = acc[~bank_w][k];
  assign o_frame_idx = frame_cnt;
  // Frame 0 overwrites, so stale data from the previous window never needs a clear pass.
  always_ff @(posedge i_50M_clk)
    if (accept) acc[bank_w][dir_cnt] <= (frame_cnt == '0) ? ext : acc[bank_w][dir_cnt] + ext;
  always_ff @(posedge i_50M_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      dir_cnt   <= '0;
      frame_cnt <= '0;
      bank_w    <= 1'b0;
    end else if (i_clear) begin
      dir_cnt   <= '0;
      frame_cnt <= '0;
    end else if (i_valid) begin
      dir_cnt <= last_dir ? '0 : dir_cnt + 1'b1;
      if (last_dir) frame_cnt <= frame_cnt + 1'b1;
      if (win_end) bank_w <= ~bank_w;
    end
  always_ff @(posedge i_50M_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    if (i_clear) state_d = IDLE;
    else if (state == IDLE && win_end) state_d = SCAN;
    else if (state == SCAN && last_k) state_d = DONE;
    else if (state == DONE) state_d = IDLE;
  end
  // The scan always reads the bank not being written; ties keep the lower index.
  always_ff @(posedge i_50M_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      k        <= '0;
      best_val <= '0;
      best_idx <= '0;
      o_valid  <= 1'b0;
      o_dir    <= '0;
      o_peak   <= '0;
    end else begin
      k       <= (state == SCAN && !i_clear && !last_k) ? k + 1'b1 : '0;
      o_valid <= state == DONE && !i_clear;
      if (state == SCAN && (k == '0 || rd > best_val)) begin
        best_val <= rd;
        best_idx <= k;
      end
      if (state == DONE && !i_clear) begin
        o_dir  <= best_idx;
        o_peak <= best_val;
      end
    end
endmodule
